// File: rtl/fetch_cycle.sv
// fetch_cycle: RV32I IF stage with imem req/gnt/rvalid fetch, prefetch FIFO and IF/ID register; `FETCH_PERF_EN adds perf counters
module fetch_cycle #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];
  logic [31:0] pc_f, resp_pc;
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, outstanding;
  logic [15:0] drop_cnt;
  logic grant, rv_hit, live_rv, push, pop, bubble;
  // outstanding counts only live requests; requests orphaned by a redirect move to drop_cnt
  assign imem_req  = !rst && !Stall_F && !PCSrc_E && ({1'b0, outstanding} + {1'b0, count} < DEPTH_W);
  assign imem_addr = pc_f;
  assign grant     = imem_req && imem_gnt;
  assign rv_hit    = imem_rvalid && (drop_cnt != '0 || outstanding != '0);
  assign live_rv   = imem_rvalid && drop_cnt == '0 && outstanding != '0;
  assign push      = live_rv && !PCSrc_E;
  assign pop       = !Flush_D && !Stall_D && count != '0;
  assign bubble    = Flush_D || (!Stall_D && count == '0);
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= imem_rdata;
      fifo_pc[wptr]   <= resp_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      Instr_D     <= NOP_INSTR;
      PC_D        <= '0;
      PCPlus4_D   <= '0;
      Valid_D     <= 1'b0;
    end else begin
      pc_f        <= PCSrc_E ? PCTarget_E : grant ? pc_f + 32'd4 : pc_f;
      resp_pc     <= PCSrc_E ? PCTarget_E : push ? resp_pc + 32'd4 : resp_pc;
      wptr        <= PCSrc_E ? '0 : wptr + AW'(push);
      rptr        <= PCSrc_E ? '0 : rptr + AW'(pop);
      count       <= PCSrc_E ? '0 : count + CW'(push) - CW'(pop);
      outstanding <= PCSrc_E ? '0 : outstanding + CW'(grant) - CW'(live_rv);
      drop_cnt    <= PCSrc_E ? drop_cnt + 16'(outstanding) + 16'(grant) - 16'(rv_hit)
                             : drop_cnt - 16'(imem_rvalid && drop_cnt != '0);
      if (bubble) begin
        Instr_D   <= NOP_INSTR;
        PC_D      <= '0;
        PCPlus4_D <= '0;
        Valid_D   <= 1'b0;
      end else if (pop) begin
        Instr_D   <= fifo_data[rptr];
        PC_D      <= fifo_pc[rptr];
        PCPlus4_D <= fifo_pc[rptr] + 32'd4;
        Valid_D   <= 1'b1;
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_bubbles <= perf_bubbles + 32'(!Flush_D && !Stall_D && count == '0);
    end
  end
`endif
endmodule
